// File: rtl/sw_test_snoop_pkg.sv
// ---------------------------------------------------------------------------
// sw_test_snoop_pkg
// Shared types and constants for the data-bus snoop that feeds
// sw_test_status_if with qualified writes.
//   entry_t      : one in-flight request as remembered by the tracker
//   QualMask     : byte enables that must both be set for a forwarded write
//   is_qualified : write && both low byte lanes enabled
// ---------------------------------------------------------------------------
package sw_test_snoop_pkg;

  // Tracker entries always carry a 32-bit address; the snoop supports
  // AddrWidth up to this value.
  localparam int EntryAddrWidth = 32;

  localparam logic [1:0] QualMask = 2'b11;

  typedef struct packed {
    logic                      qual;
    logic [EntryAddrWidth-1:0] addr;
    logic [15:0]               data;
  } entry_t;

  function automatic logic is_qualified(input logic write, input logic [1:0] mask_lo);
    return write && ((mask_lo & QualMask) == QualMask);
  endfunction

endpackage

// File: rtl/sw_test_bus_snoop_if.sv
// ---------------------------------------------------------------------------
// sw_test_bus_snoop_if
// Core data-bus request (a_*) and response (d_*) channels.
//   master  : requester view (drives a_* and d_ready)
//   slave   : responder view (drives a_ready and d_*)
//   monitor : passive observer, every signal is an input
// ---------------------------------------------------------------------------
interface sw_test_bus_snoop_if #(
  parameter int AddrWidth = 32
) ();

  logic                 a_valid;
  logic                 a_ready;
  logic                 a_write;
  logic [AddrWidth-1:0] a_addr;
  logic [31:0]          a_data;
  logic [3:0]           a_mask;
  logic                 d_valid;
  logic                 d_ready;
  logic                 d_error;

  modport master (
    output a_valid, a_write, a_addr, a_data, a_mask, d_ready,
    input  a_ready, d_valid, d_error
  );

  modport slave (
    input  a_valid, a_write, a_addr, a_data, a_mask, d_ready,
    output a_ready, d_valid, d_error
  );

  modport monitor (
    input a_valid, a_ready, a_write, a_addr, a_data, a_mask,
    input d_valid, d_ready, d_error
  );

endinterface

// File: rtl/sw_test_snoop_fifo.sv
// ---------------------------------------------------------------------------
// sw_test_snoop_fifo
// In-order tracker of outstanding bus requests (synchronous FIFO of entry_t).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push, din     : enqueue din (ignored when full unless popping this cycle)
//   pop           : dequeue head (ignored when empty)
//   dout          : current head entry, valid while !empty
//   full, empty   : occupancy flags
//   count         : occupancy, one bit wider than the pointers
// Depth must be a power of two and at least 2 so pointers wrap naturally.
// ---------------------------------------------------------------------------
module sw_test_snoop_fifo
  import sw_test_snoop_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  output entry_t                 dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int PtrWidth = $clog2(Depth);
  localparam int CntWidth = PtrWidth + 1;

  logic [PtrWidth-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PtrWidth-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CntWidth-1:0] count_reg, count_next;
  logic                do_push, do_pop;

  entry_t mem [Depth];

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CntWidth'(Depth));
  assign count = count_reg;
  assign dout  = mem[rd_ptr_reg];

  // A pop frees the slot a same-cycle push needs, so full only blocks a push
  // when nothing leaves.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CntWidth'(1);
      2'b01:   count_next = count_reg - CntWidth'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  for (genvar gi = 0; gi < Depth; gi++) begin : g_slot
    always_ff @(posedge clk_i) begin
      if (do_push && (wr_ptr_reg == PtrWidth'(gi))) begin
        mem[gi] <= din;
      end
    end
  end

endmodule

// File: rtl/sw_test_bus_snoop.sv
// ---------------------------------------------------------------------------
// sw_test_bus_snoop
// Passive monitor of the core data bus. Every accepted request is tracked in
// order; when its response is accepted without error and the request was a
// write with both low byte lanes enabled, a one-cycle write strobe is issued
// the following cycle.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   bus            : request/response channels (monitor modport, inputs only)
//   wr_valid       : qualified write strobe
//   addr, data     : address and a_data[15:0] of the last qualified write
//   outstanding_o  : number of in-flight requests
//   overflow_o     : sticky, request dropped because the tracker was full
//   underflow_o    : sticky, response seen with no tracked request
// All outputs are registered.
// ---------------------------------------------------------------------------
module sw_test_bus_snoop
  import sw_test_snoop_pkg::*;
#(
  parameter int AddrWidth      = 32,
  parameter int MaxOutstanding = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  sw_test_bus_snoop_if.monitor            bus,
  output logic                            wr_valid,
  output logic [AddrWidth-1:0]            addr,
  output logic [15:0]                     data,
  output logic [$clog2(MaxOutstanding):0] outstanding_o,
  output logic                            overflow_o,
  output logic                            underflow_o
);

  logic a_hs, d_hs;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  entry_t push_entry, head;

  logic                 wr_valid_reg, wr_valid_next;
  logic [AddrWidth-1:0] addr_reg, addr_next;
  logic [15:0]          data_reg, data_next;
  logic                 overflow_reg, overflow_next;
  logic                 underflow_reg, underflow_next;

  // Upper data and mask lanes never influence the forwarded stream.
  logic unused_bits;
  assign unused_bits = ^{bus.a_data[31:16], bus.a_mask[3:2]};

  assign a_hs = bus.a_valid && bus.a_ready;
  assign d_hs = bus.d_valid && bus.d_ready;

  // Reads are tracked as well so each response lines up with its request.
  assign push_entry = '{
    qual: is_qualified(bus.a_write, bus.a_mask[1:0]),
    addr: EntryAddrWidth'(bus.a_addr),
    data: bus.a_data[15:0]
  };

  assign fifo_pop  = d_hs && !fifo_empty;
  assign fifo_push = a_hs && (!fifo_full || fifo_pop);

  sw_test_snoop_fifo #(
    .Depth (MaxOutstanding)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding_o)
  );

  always_comb begin
    wr_valid_next  = fifo_pop && head.qual && !bus.d_error;
    addr_next      = addr_reg;
    data_next      = data_reg;
    if (wr_valid_next) begin
      addr_next = head.addr[AddrWidth-1:0];
      data_next = head.data;
    end
    overflow_next  = overflow_reg  || (a_hs && fifo_full && !fifo_pop);
    underflow_next = underflow_reg || (d_hs && fifo_empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_valid_reg  <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_valid_reg  <= wr_valid_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign wr_valid    = wr_valid_reg;
  assign addr        = addr_reg;
  assign data        = data_reg;
  assign overflow_o  = overflow_reg;
  assign underflow_o = underflow_reg;

endmodule
